// File: rtl/sci_acc_pkg.sv
// sci_acc_pkg: shared response-buffer widths, FSM state enum and FIFO entry layout
package sci_acc_pkg;
  localparam int DATA_W = 36;
  localparam int SEQ_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} resp_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } resp_entry_t;
endpackage

// File: rtl/sci_acc_resp_buf_if.sv
// sci_acc_resp_buf_if: tagged result stream to the RAM write stage; master drives vld/data/seq/last, slave drives rdy
interface sci_acc_resp_buf_if #(
  parameter int DATA_W = 36,
  parameter int SEQ_W  = 8
);
  logic              vld;
  logic [DATA_W-1:0] data;
  logic [SEQ_W-1:0]  seq;
  logic              last;
  logic              rdy;
  modport master (output vld, data, seq, last, input rdy);
  modport slave  (input vld, data, seq, last, output rdy);
endinterface

// File: rtl/sci_acc_fwft_fifo.sv
// sci_acc_fwft_fifo: first-word-fall-through FIFO (push must already be qualified against full; pop is ignored when empty; dout/empty/count/full are registered-state views)
module sci_acc_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == CW'(DEPTH);
  assign count  = cnt_q;
  assign dout   = mem_q[rp_q];
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push);
      rp_q  <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sci_acc_resp_buf.sv
// sci_acc_resp_buf: tags core results with a batch sequence number and buffers them for the RAM write DMA; in_* core side, req_issue/batch_done_in batch control, out stream, occupancy/batch_cmpl/sticky errors status
module sci_acc_resp_buf #(
  parameter int DATA_W       = 36,
  parameter int DEPTH        = 16,
  parameter int SEQ_W        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_push,
  output logic                     in_ready,
  input  logic                     req_issue,
  input  logic                     batch_done_in,
  sci_acc_resp_buf_if.master       out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     batch_cmpl,
  output logic                     ovf_err,
  output logic                     unexp_err
);
  import sci_acc_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = SEQ_W + 1;
  resp_state_e      state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic             in_ready_q, ovf_q, unexp_q;
  logic             full, empty, pop, push_acc, no_outst;
  logic [CW-1:0]    cnt, cnt_d;
  resp_entry_t      din, dout;
  assign pop      = !empty && out.rdy;
  assign push_acc = in_push && (!full || pop);
  assign no_outst = outst_q == '0;
  assign cnt_d    = cnt + CW'(push_acc) - CW'(pop);
  assign din      = '{data: in_data, seq: seq_q};
  sci_acc_fwft_fifo #(
    .WIDTH ($bits(resp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push_acc),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q + SEQ_W'(push_acc);
    outst_d = outst_q + OW'(req_issue) - OW'(in_push && !no_outst);
    unique case (state_q)
      IDLE: begin
        state_d = req_issue ? RUN : batch_done_in ? DRAIN : IDLE;
        seq_d   = req_issue ? '0 : seq_d;
      end
      RUN:   state_d = batch_done_in ? DRAIN : RUN;
      DRAIN: state_d = (no_outst && cnt == '0 && !in_push) ? DONE : DRAIN;
      DONE:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      outst_q    <= '0;
      in_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      outst_q    <= outst_d;
      in_ready_q <= (CW'(DEPTH) - cnt_d) > CW'(AFULL_MARGIN);
      ovf_q      <= ovf_q || (in_push && full && !pop);
      unexp_q    <= unexp_q || (in_push && no_outst);
    end
  end
  assign out.vld    = !empty;
  assign out.data   = dout.data;
  assign out.seq    = dout.seq;
  assign out.last   = !empty && state_q == DRAIN && no_outst && cnt == CW'(1) && !in_push;
  assign in_ready   = in_ready_q;
  assign occupancy  = cnt;
  assign batch_cmpl = state_q == DONE;
  assign ovf_err    = ovf_q;
  assign unexp_err  = unexp_q;
endmodule

// File: doc/sci_acc_resp_buf.md
Name: sci_acc_resp_buf

Overview:
Result buffer between the compute core and the RAM write DMA. It captures each computed result on the core's op_done pulse and tags it with a per-batch sequence number. Results are presented to the RAM write stage through a valid/ready handshake. The block counts outstanding requests so it can flag the final result of a batch and pulse batch completion once every issued request has been written out.

Parameters:
DATA_W, 36, result word width (matches the response FIFO data width constant)
DEPTH, 16, FIFO entries; power of two, minimum 4
SEQ_W, 8, sequence tag width
AFULL_MARGIN, 2, in_ready deasserts when free entries <= AFULL_MARGIN, which covers the core's pipeline skid

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_data  in  DATA_W  result from the compute core
in_push  in  1  single-cycle result strobe (core op_done)
in_ready  out  1  space available; feeds the core's result_fifo_ready
req_issue  in  1  pulse per request accepted by the core (req_vld & core_ready)
batch_done_in  in  1  pulse from the ROM DMA when all batch requests have been issued
out_vld  out  1  head entry valid
out_data  out  DATA_W  head result
out_seq  out  SEQ_W  head sequence tag
out_last  out  1  head is the final result of the batch
out_rdy  in  1  RAM write stage accepts the head
occupancy  out  $clog2(DEPTH)+1  entries held
batch_cmpl  out  1  one-cycle pulse when the batch is fully drained
ovf_err  out  1  sticky: push dropped because the FIFO was full
unexp_err  out  1  sticky: push received with zero outstanding requests

Behaviour:
- One clock domain (clk). reset_n is asynchronous and active-low.
- Reset values: all outputs 0, except in_ready = 1. Pointers, counts, seq and outstanding are 0. FSM is in IDLE.
- A reset mid-batch discards all buffered entries and clears both sticky errors.
- FIFO is first-word-fall-through. A push into an empty FIFO gives out_vld = 1 in the next cycle (latency 1).
- Pop occurs when out_vld & out_rdy. out_data, out_seq and out_last must hold stable while out_vld & !out_rdy.
- Push acceptance:
  - Accept when in_push & (!full | pop in the same cycle).
  - When full with no pop, drop the word and set ovf_err. Pointers and seq are unchanged.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When empty, a push plus pop in the same cycle is impossible (out_vld = 0). The push simply lands.
- in_ready = (DEPTH - occupancy) > AFULL_MARGIN, registered from the next-state occupancy.
- Pushes arriving while in_ready = 0 are still accepted if not full.
- Pointers wrap modulo DEPTH.
- Sequence tag:
  - seq increments on each accepted push and wraps from 2^SEQ_W - 1 to 0.
  - Stored with the entry.
  - Cleared on the IDLE->RUN transition.
- Outstanding counter (SEQ_W+1 bits):
  - +1 on req_issue, -1 on accepted push; both in the same cycle leaves it unchanged.
  - A push with outstanding = 0 sets unexp_err and does not decrement.
  - A dropped (overflow) push still decrements, because the request has completed.
- FSM:
  - IDLE: req_issue -> RUN.
  - RUN: batch_done_in -> DRAIN. A batch_done_in arriving in IDLE with no issue goes directly to DRAIN.
  - DRAIN: when outstanding = 0 & occupancy = 0 & no push this cycle -> DONE.
  - DONE: batch_cmpl = 1 for exactly one cycle -> IDLE.
  - req_issue during DRAIN/DONE is counted in outstanding. It does not change state; the new batch starts after IDLE.
- out_last = out_vld & (state == DRAIN) & (outstanding == 0) & (occupancy == 1) & !in_push. It is combinational from registered state.

Decomposition:
- Shared package sci_acc_pkg holds DATA_W (the response FIFO width constant), the resp_state_e enum {IDLE, RUN, DRAIN, DONE}, and the resp_entry_t struct {data, seq}.
- One sub-module: sci_acc_fwft_fifo (generic FWFT FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/count).
- Sequence, outstanding and FSM logic live in sci_acc_resp_buf.

Test Plan:
- Basic flow:
  - Stimulus: 3 req_issue, then 3 pushes of 0x1, 0x2, 0x3 with out_rdy = 1, then batch_done_in.
  - Required: out_seq 0, 1, 2 in order; out_last on the third only if batch_done_in precedes its pop; batch_cmpl pulses once after the FIFO is empty.
- Backpressure/full:
  - Stimulus: out_rdy = 0, 17 issues, 17 pushes (DEPTH = 16).
  - Required: in_ready falls at occupancy 14; the 17th push is dropped; ovf_err = 1; occupancy = 16; outstanding = 0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_rdy = 1 and in_push in the same cycle.
  - Required: push accepted, occupancy stays 16, no ovf_err.
- Sequence wrap:
  - Stimulus: 260 issue/push pairs streamed.
  - Required: out_seq goes 255 -> 0 -> 1 -> 2 -> 3, with no errors.
- Unexpected push:
  - Stimulus: push with no prior req_issue.
  - Required: unexp_err = 1, entry still buffered, outstanding stays 0.
- Reset mid-batch:
  - Stimulus: assert reset_n = 0 with 5 entries queued and outstanding = 3.
  - Required: out_vld = 0 immediately (asynchronous), in_ready = 1, errors cleared, FSM in IDLE, no batch_cmpl pulse.
